uart_frame_parser: RTL

Byte-level framing stage directly downstream of the UART receiver. It consumes the receiver's byte strobe and data, and assembles framed commands of the form SYNC, CMD, LEN, PAYLOAD[0..LEN-1], CHK. It validates length and XOR checksum, enforces an inter-byte timeout, and presents completed frames to the command layer. It also decodes the baud-change command and drives the receiver's speed/set_speed inputs, closing the loop.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_frame_parser_if.sv | 29 ++
 rtl/uart_timeout_ctr.sv | 31 +++
 rtl/uart_frame_parser.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parser FSM states,
// error codes, and default frame/speed constants (also used by uart_rx).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4
    } parser_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CHK     = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0]  SPEED_CMD_DEFAULT = 8'h01;
    localparam logic [12:0] SPEED_DEFAULT     = 13'h1869;

    // Running XOR checksum step.
    function automatic logic [7:0] checksum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte stream in, framed command and receiver speed control out.
interface uart_frame_parser_if #(
    parameter int MAX_PAYLOAD = 4
);
    logic                       byte_valid;
    logic [7:0]                 byte_data;
    logic                       frame_valid;
    logic [7:0]                 frame_cmd;
    logic [2:0]                 frame_len;
    logic [8*MAX_PAYLOAD-1:0]   frame_payload;
    logic                       frame_error;
    logic [1:0]                 err_code;
    logic [12:0]                speed;
    logic                       set_speed;

    // Byte source / command consumer side.
    modport master (
        output byte_valid, byte_data,
        input  frame_valid, frame_cmd, frame_len, frame_payload,
        input  frame_error, err_code, speed, set_speed
    );

    // Parser side.
    modport slave (
        input  byte_valid, byte_data,
        output frame_valid, frame_cmd, frame_len, frame_payload,
        output frame_error, err_code, speed, set_speed
    );
endinterface

// File: rtl/uart_timeout_ctr.sv
// Inter-byte timeout counter: cleared by each accepted byte, counts only
// while a frame is in progress, and flags expiry when the count reaches
// TIMEOUT_CYCLES-1 unless a byte arrives in that same cycle.
module uart_timeout_ctr #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [15:0] r_cnt;
    logic        w_at_limit;

    assign w_at_limit = (r_cnt == (TIMEOUT_CYCLES - 16'd1));
    assign o_expire   = i_enable & ~i_clear & w_at_limit;

    // Count idle cycles inside a frame; restart on byte, idle or expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 16'd0;
        end else if (i_clear || !i_enable || o_expire) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame assembler for SYNC, CMD, LEN, PAYLOAD[], CHK byte streams.
// Validates length and XOR checksum, enforces an inter-byte timeout,
// publishes good frames and reprograms the receiver speed on request.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int          MAX_PAYLOAD    = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter logic [7:0]  SPEED_CMD      = SPEED_CMD_DEFAULT,
    parameter logic [12:0] SPEED_DEF      = SPEED_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_frame_parser_if.slave   bus
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_PAYLOAD);
    localparam int         PW        = 8 * MAX_PAYLOAD;

    parser_state_t   r_state;
    logic            r_bv_prev;
    logic [7:0]      r_cmd;
    logic [2:0]      r_len;
    logic [2:0]      r_idx;
    logic [7:0]      r_chk;
    logic [PW-1:0]   r_shadow;

    logic            r_frame_valid;
    logic            r_frame_error;
    logic [1:0]      r_err_code;
    logic [7:0]      r_frame_cmd;
    logic [2:0]      r_frame_len;
    logic [PW-1:0]   r_frame_payload;
    logic [12:0]     r_speed;
    logic            r_set_speed;

    logic            w_accept;
    logic            w_expire;
    logic            w_busy;
    logic [12:0]     w_speed_val;
    logic            w_speed_ok;

    // A held strobe yields one byte: only its rising edge is accepted.
    assign w_accept = bus.byte_valid & ~r_bv_prev;
    assign w_busy   = (r_state != ST_IDLE);

    // Speed value is only meaningful when a two-byte payload fits.
    generate
        if (MAX_PAYLOAD >= 2) begin : g_speed
            assign w_speed_val = {r_shadow[12:8], r_shadow[7:0]};
            assign w_speed_ok  = 1'b1;
        end else begin : g_nospeed
            assign w_speed_val = 13'd0;
            assign w_speed_ok  = 1'b0;
        end
    endgenerate

    uart_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_accept),
        .i_enable (w_busy),
        .o_expire (w_expire)
    );

    // Remember the previous strobe level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bv_prev <= 1'b0;
        end else begin
            r_bv_prev <= bus.byte_valid;
        end
    end

    // Frame FSM with registered result/pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cmd           <= 8'd0;
            r_len           <= 3'd0;
            r_idx           <= 3'd0;
            r_chk           <= 8'd0;
            r_shadow        <= '0;
            r_frame_valid   <= 1'b0;
            r_frame_error   <= 1'b0;
            r_err_code      <= ERR_NONE;
            r_frame_cmd     <= 8'd0;
            r_frame_len     <= 3'd0;
            r_frame_payload <= '0;
            r_speed         <= SPEED_DEF;
            r_set_speed     <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
            r_set_speed   <= 1'b0;
            if (w_expire) begin
                r_frame_error <= 1'b1;
                r_err_code    <= ERR_TIMEOUT;
                r_state       <= ST_IDLE;
            end else if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.byte_data == SYNC_BYTE) begin
                            r_state <= ST_CMD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_CMD: begin
                        r_cmd   <= bus.byte_data;
                        r_chk   <= bus.byte_data;
                        r_state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (bus.byte_data > MAX_LEN_B) begin
                            r_frame_error <= 1'b1;
                            r_err_code    <= ERR_LEN;
                            r_state       <= ST_IDLE;
                        end else begin
                            r_len    <= bus.byte_data[2:0];
                            r_chk    <= checksum_step(r_chk, bus.byte_data);
                            r_shadow <= '0;
                            r_idx    <= 3'd0;
                            if (bus.byte_data == 8'd0) begin
                                r_state <= ST_CHECK;
                            end else begin
                                r_state <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        r_shadow[{r_idx, 3'b000} +: 8] <= bus.byte_data;
                        r_chk <= checksum_step(r_chk, bus.byte_data);
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == (r_len - 3'd1)) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_state <= ST_PAYLOAD;
                        end
                    end
                    ST_CHECK: begin
                        if (bus.byte_data == r_chk) begin
                            r_frame_valid   <= 1'b1;
                            r_frame_cmd     <= r_cmd;
                            r_frame_len     <= r_len;
                            r_frame_payload <= r_shadow;
                            if (w_speed_ok && (r_cmd == SPEED_CMD) && (r_len == 3'd2)) begin
                                r_speed     <= w_speed_val;
                                r_set_speed <= 1'b1;
                            end else begin
                                r_speed     <= r_speed;
                            end
                        end else begin
                            r_frame_error <= 1'b1;
                            r_err_code    <= ERR_CHK;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign bus.frame_valid   = r_frame_valid;
    assign bus.frame_error   = r_frame_error;
    assign bus.err_code      = r_err_code;
    assign bus.frame_cmd     = r_frame_cmd;
    assign bus.frame_len     = r_frame_len;
    assign bus.frame_payload = r_frame_payload;
    assign bus.speed         = r_speed;
    assign bus.set_speed     = r_set_speed;

endmodule
